serial_ripple_subtractor16: RTL and testbench



---
 rtl/serial_ripple_subtractor16.sv | 109 ++++++++++
 tb/tb_serial_ripple_subtractor16.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/serial_ripple_subtractor16.sv
// Bit-serial subtractor: one full-subtractor cell walks LSB to MSB, one bit per clock.
// The result is packed as {zeros, borrow_out, difference}, the same layout the ripple adder uses.
module serial_ripple_subtractor16 #(
    parameter int WIDTH     = 16,
    parameter int OUT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic                 Bin,
    output logic                 busy,
    output logic                 done,
    output logic [OUT_WIDTH-1:0] Diff
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t               state;
    state_t               state_next;
    logic [WIDTH-1:0]     a_sh;
    logic [WIDTH-1:0]     b_sh;
    logic [WIDTH-1:0]     d_sh;
    logic                 br;
    logic [CW-1:0]        cnt;
    logic                 load;
    logic                 step;
    logic                 finish;
    logic                 d;
    logic                 br_next;
    logic [WIDTH-1:0]     d_final;
    logic [OUT_WIDTH-1:0] result;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt == LAST) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Full-subtractor cell on the current LSBs; the completion edge uses d_final so the last bit lands directly in Diff.
    always_comb begin
        d       = a_sh[0] ^ b_sh[0] ^ br;
        br_next = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
        d_final = {d, d_sh[WIDTH-1:1]};
        result  = '0;
        result[WIDTH:0] = {br_next, d_final};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh <= '0;
            b_sh <= '0;
            d_sh <= '0;
            br   <= 1'b0;
            cnt  <= '0;
            done <= 1'b0;
            Diff <= '0;
        end else begin
            done <= finish;
            if (load) begin
                a_sh <= A;
                b_sh <= B;
                br   <= Bin;
                cnt  <= '0;
            end else if (step) begin
                a_sh <= a_sh >> 1;
                b_sh <= b_sh >> 1;
                d_sh <= d_final;
                br   <= br_next;
                cnt  <= cnt + CW'(1);
            end
            if (finish) begin
                Diff <= result;
            end
        end
    end

    assign busy = (state == RUN);

endmodule

// File: tb/tb_serial_ripple_subtractor16.sv
// Self-checking bench for serial_ripple_subtractor16: directed table, multi-cycle corner cases, random vectors.
module tb_serial_ripple_subtractor16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] A = '0;
    logic [15:0] B = '0;
    logic        Bin = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] Diff;

    int vectors = 0;
    int miscompares = 0;

    serial_ripple_subtractor16 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .Bin   (Bin),
        .busy  (busy),
        .done  (done),
        .Diff  (Diff)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        bin;
        logic [31:0] exp;
    } vec_t;

    vec_t table_v[7];

    // Reference: plain integer subtraction, keeping 16 difference bits plus the borrow bit.
    function automatic logic [31:0] ref_diff(input logic [15:0] a, input logic [15:0] b, input logic bin);
        logic [31:0] r;
        r = {16'b0, a} - {16'b0, b} - {31'b0, bin};
        return r & 32'h0001_FFFF;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // The upper result bits must stay zero at all times.
    always @(negedge clk) begin
        if (rst_n && Diff[31:17] !== 15'b0) begin
            miscompares++;
            $display("[TB] FAIL upper_zero: got 0x%08h, expected 0x0000_0000 in bits 31:17", Diff);
        end
    end

    // Called at posedge+1 with the DUT idle (or in its done cycle); runs one operation to completion.
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic bin,
                                 input logic [31:0] exp, input string name);
        logic [31:0] prev;
        int lat;
        prev = Diff;
        lat  = 0;
        A = a; B = b; Bin = bin; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput({name, " busy_after_start"}, {31'b0, busy}, 32'd1);
        checkOutput({name, " done_low_after_start"}, {31'b0, done}, 32'd0);
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (n == 8) checkOutput({name, " diff_held"}, Diff, prev);
            if (done) begin
                lat = n;
                break;
            end
        end
        checkOutput({name, " latency"}, 32'(lat), 32'd16);
        checkOutput({name, " diff"}, Diff, exp);
        checkOutput({name, " busy_at_done"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        int lat;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rbin;

        table_v[0] = '{16'h0000, 16'h0000, 1'b0, 32'h0000_0000};
        table_v[1] = '{16'h0005, 16'h0003, 1'b0, 32'h0000_0002};
        table_v[2] = '{16'hAAAA, 16'h5555, 1'b0, 32'h0000_5555};
        table_v[3] = '{16'h0000, 16'h0001, 1'b0, 32'h0001_FFFF};
        table_v[4] = '{16'h8000, 16'h0001, 1'b0, 32'h0000_7FFF};
        table_v[5] = '{16'h0000, 16'h0000, 1'b1, 32'h0001_FFFF};
        table_v[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 32'h0001_FFFF};

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset busy", {31'b0, busy}, 32'd0);
        checkOutput("reset done", {31'b0, done}, 32'd0);
        checkOutput("reset diff", Diff, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            applyStimulus(table_v[i].a, table_v[i].b, table_v[i].bin, table_v[i].exp, $sformatf("vec%0d", i));
            @(posedge clk); #1;
            checkOutput($sformatf("vec%0d done_pulse_width", i), {31'b0, done}, 32'd0);
        end

        // A second start while busy must be ignored.
        A = 16'd5; B = 16'd3; Bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            if (n == 7) begin A = 16'd9; B = 16'd9; start = 1'b1; end
            if (n == 8) start = 1'b0;
            @(posedge clk); #1;
            if (done) begin
                lat = n;
                break;
            end
        end
        start = 1'b0;
        checkOutput("ignore latency", 32'(lat), 32'd16);
        checkOutput("ignore diff", Diff, 32'h0000_0002);

        // Start held during the done cycle is accepted with no gap.
        applyStimulus(16'd10, 16'd4, 1'b0, 32'h0000_0006, "back2back");

        // Asynchronous reset in the middle of an operation.
        @(posedge clk); #1;
        A = 16'd0; B = 16'd1; Bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("abort busy", {31'b0, busy}, 32'd0);
        checkOutput("abort diff", Diff, 32'd0);
        checkOutput("abort done", {31'b0, done}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (done) lat = n;
        end
        checkOutput("abort no_done", 32'(lat), 32'd0);
        checkOutput("abort diff_after", Diff, 32'd0);
        applyStimulus(16'd5, 16'd3, 1'b0, 32'h0000_0002, "after_abort");

        for (int i = 0; i < 1000; i++) begin
            ra   = 16'($urandom);
            rb   = 16'($urandom);
            rbin = 1'($urandom);
            applyStimulus(ra, rb, rbin, ref_diff(ra, rb, rbin), $sformatf("rand%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
